// File: rtl/move_command_generator.sv
`timescale 1ns/1ps
// Player move command producer: button conditioning, LEFT/RIGHT auto-repeat,
// single-entry pending flags and a strobe sequencer driving move/move_valid/move_clk.

package tetris_pkg;
  typedef enum logic [1:0] {
    CMD_NONE   = 2'd0,
    CMD_LEFT   = 2'd1,
    CMD_RIGHT  = 2'd2,
    CMD_ROTATE = 2'd3
  } command_t;
endpackage

// state  | meaning
// IDLE   | outputs parked, waiting for a pending flag
// SETUP  | winning command presented, move_clk low for one cycle
// STROBE | move_clk high for STROBE_CYCLES
// HOLD   | move_clk low, command still held for GAP_CYCLES
module move_command_generator #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned REPEAT_DELAY    = 6_000_000,
  parameter int unsigned REPEAT_PERIOD   = 2_000_000,
  parameter int unsigned STROBE_CYCLES   = 4,
  parameter int unsigned GAP_CYCLES      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_rotate,
  output tetris_pkg::command_t move,
  output logic                 move_valid,
  output logic                 move_clk,
  output logic [7:0]           cmd_count
);
  import tetris_pkg::*;

  localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TM_MAX = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RP_W = (RP_MAX > 2) ? $clog2(RP_MAX) : 1;
  localparam int TM_W = (TM_MAX > 2) ? $clog2(TM_MAX) : 1;

  localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RD_LOAD = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RP_LOAD = RP_W'(REPEAT_PERIOD - 1);
  localparam logic [TM_W-1:0] ST_LOAD = TM_W'(STROBE_CYCLES - 1);
  localparam logic [TM_W-1:0] GP_LOAD = TM_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  // bit 0 = LEFT, bit 1 = RIGHT, bit 2 = ROTATE
  logic [2:0]      sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]      deb_q, deb_d;
  logic [DB_W-1:0] deb_cnt_q [3];
  logic [DB_W-1:0] deb_cnt_d [3];
  logic [RP_W-1:0] rpt_cnt_q [2];
  logic [RP_W-1:0] rpt_cnt_d [2];
  logic [2:0]      pend_q, pend_d;
  logic [2:0]      press, evt, pend_clr;
  logic [1:0]      rpt_evt;
  logic            conflict;

  state_t          state_q, state_d;
  logic [TM_W-1:0] tmr_q, tmr_d;
  command_t        move_q, move_d;
  logic            valid_q, valid_d;
  logic            mclk_q, mclk_d;
  logic [7:0]      count_q, count_d;

  // Two-flop synchronizers
  always_comb begin
    sync1_d = {btn_rotate, btn_right, btn_left};
    sync2_d = sync1_q;
  end

  // Debounce: down-counter restarts whenever the synchronized level matches the accepted one
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      deb_cnt_d[i] = DB_LOAD;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == '0) deb_d[i] = sync2_q[i];
        else                    deb_cnt_d[i] = deb_cnt_q[i] - DB_W'(1);
      end
    end
    press = deb_d & ~deb_q;
  end

  // Auto-repeat timers for LEFT/RIGHT; a release (deb_d low) stops them in the same cycle
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rpt_evt[i]   = 1'b0;
      rpt_cnt_d[i] = rpt_cnt_q[i];
      if (press[i]) begin
        rpt_cnt_d[i] = RD_LOAD;
      end else if (deb_q[i] && deb_d[i]) begin
        if (rpt_cnt_q[i] == '0) begin
          rpt_evt[i]   = 1'b1;
          rpt_cnt_d[i] = RP_LOAD;
        end else begin
          rpt_cnt_d[i] = rpt_cnt_q[i] - RP_W'(1);
        end
      end
    end
  end

  // Event filtering and pending flags; a simultaneous LEFT+RIGHT press resolves to LEFT
  always_comb begin
    conflict = deb_d[0] & deb_d[1];
    evt[0]   = (press[0] | rpt_evt[0]) & (~conflict | (press[0] & press[1]));
    evt[1]   = (press[1] | rpt_evt[1]) & ~conflict;
    evt[2]   = press[2];
    pend_d   = evt | (pend_q & ~pend_clr);
  end

  // Sequencer next state; output registers take the value of the state being entered
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    move_d   = move_q;
    valid_d  = valid_q;
    mclk_d   = mclk_q;
    count_d  = count_q;
    pend_clr = '0;
    case (state_q)
      IDLE: begin
        move_d  = CMD_NONE;
        valid_d = 1'b0;
        mclk_d  = 1'b0;
        if (pend_q != '0) begin
          state_d = SETUP;
          valid_d = 1'b1;
          if (pend_q[0]) begin
            move_d      = CMD_LEFT;
            pend_clr[0] = 1'b1;
          end else if (pend_q[1]) begin
            move_d      = CMD_RIGHT;
            pend_clr[1] = 1'b1;
          end else begin
            move_d      = CMD_ROTATE;
            pend_clr[2] = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d = STROBE;
        mclk_d  = 1'b1;
        tmr_d   = ST_LOAD;
        count_d = count_q + 8'd1;
      end
      STROBE: begin
        if (tmr_q == '0) begin
          state_d = HOLD;
          mclk_d  = 1'b0;
          tmr_d   = GP_LOAD;
        end else begin
          tmr_d = tmr_q - TM_W'(1);
        end
      end
      HOLD: begin
        if (tmr_q == '0) begin
          state_d = IDLE;
          move_d  = CMD_NONE;
          valid_d = 1'b0;
        end else begin
          tmr_d = tmr_q - TM_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= DB_LOAD;
      for (int i = 0; i < 2; i++) rpt_cnt_q[i] <= '0;
      pend_q  <= '0;
      state_q <= IDLE;
      tmr_q   <= '0;
      move_q  <= CMD_NONE;
      valid_q <= 1'b0;
      mclk_q  <= 1'b0;
      count_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      for (int i = 0; i < 2; i++) rpt_cnt_q[i] <= rpt_cnt_d[i];
      pend_q  <= pend_d;
      state_q <= state_d;
      tmr_q   <= tmr_d;
      move_q  <= move_d;
      valid_q <= valid_d;
      mclk_q  <= mclk_d;
      count_q <= count_d;
    end
  end

  assign move       = move_q;
  assign move_valid = valid_q;
  assign move_clk   = mclk_q;
  assign cmd_count  = count_q;

endmodule

// File: tb/tb_move_command_generator.sv
`timescale 1ns/1ps
// Bench for move_command_generator: expected commands are queued as buttons are driven
// and popped by a monitor on every move_clk rise.
module tb_move_command_generator;
  import tetris_pkg::*;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
  localparam int SC  = 2;
  localparam int GC  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_rotate = 1'b0;
  command_t   move;
  logic       move_valid, move_clk;
  logic [7:0] cmd_count;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  command_t   exp_q[$];
  int         rise_q[$];
  logic [7:0] exp_count = 8'd0;

  command_t   move_prev = CMD_NONE;
  command_t   hold_cmd = CMD_NONE;
  command_t   e_cmd;
  logic       valid_prev = 1'b0, clk_prev = 1'b0;
  int         hold_left = 0;

  move_command_generator #(
    .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .STROBE_CYCLES(SC), .GAP_CYCLES(GC)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_left(btn_left), .btn_right(btn_right), .btn_rotate(btn_rotate),
    .move(move), .move_valid(move_valid), .move_clk(move_clk), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  // Strobe monitor: scoreboard pop on each rise, stability of move/move_valid around it
  always @(posedge clk) begin
    #1;
    cyc++;
    if (reset) begin
      hold_left = 0;
    end else begin
      if (move_clk === 1'b1 && clk_prev === 1'b0) begin
        rise_q.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL strobe_unexpected at cycle %0d move=%0d", cyc, move);
        end else begin
          e_cmd = exp_q.pop_front();
          if (move !== e_cmd) begin
            errors++;
            $display("FAIL strobe_cmd at cycle %0d got %0d want %0d", cyc, move, e_cmd);
          end
        end
        checks++;
        if (valid_prev !== 1'b1 || move_valid !== 1'b1 || move_prev !== move) begin
          errors++;
          $display("FAIL strobe_setup at cycle %0d prev_valid=%b prev_move=%0d move=%0d want valid 1 before rise",
                   cyc, valid_prev, move_prev, move);
        end
      end
      if (move_clk === 1'b1 && clk_prev === 1'b1) begin
        checks++;
        if (move_valid !== 1'b1 || move !== move_prev) begin
          errors++;
          $display("FAIL strobe_stable at cycle %0d valid=%b move=%0d want 1/%0d", cyc, move_valid, move, move_prev);
        end
      end
      if (move_clk === 1'b0 && clk_prev === 1'b1) begin
        hold_left = GC;
        hold_cmd  = move_prev;
      end
      if (hold_left > 0) begin
        checks++;
        if (move_valid !== 1'b1 || move !== hold_cmd) begin
          errors++;
          $display("FAIL hold_stable at cycle %0d valid=%b move=%0d want 1/%0d", cyc, move_valid, move, hold_cmd);
        end
        hold_left--;
      end
    end
    move_prev  = move;
    valid_prev = move_valid;
    clk_prev   = move_clk;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_cmd(input command_t c);
    exp_q.push_back(c);
    exp_count = exp_count + 8'd1;
  endtask

  task automatic test_reset;
    btn_left = 1'b1; btn_right = 1'b1; btn_rotate = 1'b1;
    reset = 1'b1;
    repeat (5) begin
      @(posedge clk); #2;
      checks++;
      if (move !== CMD_NONE || move_valid !== 1'b0 || move_clk !== 1'b0 || cmd_count !== 8'd0) begin
        errors++;
        $display("FAIL reset_outputs got move=%0d valid=%b clk=%b count=%0d want 0/0/0/0",
                 move, move_valid, move_clk, cmd_count);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    expect_cmd(CMD_LEFT);
    expect_cmd(CMD_ROTATE);
    tick(30);
    btn_left = 1'b0; btn_right = 1'b0; btn_rotate = 1'b0;
    tick(40);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_missing got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (cmd_count !== exp_count) begin
      errors++;
      $display("FAIL reset_count got %0d want %0d", cmd_count, exp_count);
    end
  endtask

  task automatic test_glitch;
    rise_q.delete();
    btn_left = 1'b1;
    tick(3);
    btn_left = 1'b0;
    tick(30);
    checks++;
    if (rise_q.size() != 0 || cmd_count !== exp_count) begin
      errors++;
      $display("FAIL glitch_rejected got strobes=%0d count=%0d want 0/%0d", rise_q.size(), cmd_count, exp_count);
    end
  endtask

  task automatic test_single_left;
    int t0;
    rise_q.delete();
    btn_left = 1'b1;
    t0 = cyc;
    expect_cmd(CMD_LEFT);
    tick(10);
    btn_left = 1'b0;
    tick(40);
    checks++;
    if (rise_q.size() != 1) begin
      errors++;
      $display("FAIL single_count got %0d strobes want 1", rise_q.size());
    end else begin
      checks++;
      if (rise_q[0] - t0 > 2 + DEB + 3 || rise_q[0] - t0 < 1) begin
        errors++;
        $display("FAIL single_latency got %0d cycles want <= %0d", rise_q[0] - t0, 2 + DEB + 3);
      end
    end
    checks++;
    if (exp_q.size() != 0 || cmd_count !== exp_count) begin
      errors++;
      $display("FAIL single_done got pending=%0d count=%0d want 0/%0d", exp_q.size(), cmd_count, exp_count);
      exp_q.delete();
    end
  endtask

  task automatic test_repeat_right;
    int t0;
    int offs[$];
    rise_q.delete();
    btn_right = 1'b1;
    t0 = cyc;
    expect_cmd(CMD_RIGHT);
    offs.push_back(0);
    for (int t = RD; t < 60; t += RP) begin
      expect_cmd(CMD_RIGHT);
      offs.push_back(t);
    end
    tick(60);
    btn_right = 1'b0;
    tick(40);
    checks++;
    if (rise_q.size() != offs.size()) begin
      errors++;
      $display("FAIL repeat_count got %0d strobes want %0d", rise_q.size(), offs.size());
    end else begin
      for (int i = 1; i < offs.size(); i++) begin
        checks++;
        if (rise_q[i] - rise_q[0] > offs[i] + 1 || rise_q[i] - rise_q[0] < offs[i] - 1) begin
          errors++;
          $display("FAIL repeat_phase[%0d] got offset %0d want %0d", i, rise_q[i] - rise_q[0], offs[i]);
        end
      end
      checks++;
      if (rise_q[rise_q.size()-1] > t0 + 60 + 2 + DEB + 1) begin
        errors++;
        $display("FAIL repeat_after_release got rise at %0d want <= %0d", rise_q[rise_q.size()-1], t0 + 60 + 2 + DEB + 1);
      end
    end
    checks++;
    if (exp_q.size() != 0 || cmd_count !== exp_count) begin
      errors++;
      $display("FAIL repeat_done got pending=%0d count=%0d want 0/%0d", exp_q.size(), cmd_count, exp_count);
      exp_q.delete();
    end
  endtask

  task automatic test_rotate;
    rise_q.delete();
    btn_rotate = 1'b1;
    expect_cmd(CMD_ROTATE);
    tick(60);
    btn_rotate = 1'b0;
    tick(40);
    checks++;
    if (rise_q.size() != 1 || exp_q.size() != 0 || cmd_count !== exp_count) begin
      errors++;
      $display("FAIL rotate_once got strobes=%0d pending=%0d count=%0d want 1/0/%0d",
               rise_q.size(), exp_q.size(), cmd_count, exp_count);
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back;
    rise_q.delete();
    btn_left = 1'b1; btn_rotate = 1'b1;
    expect_cmd(CMD_LEFT);
    expect_cmd(CMD_ROTATE);
    tick(10);
    btn_left = 1'b0; btn_rotate = 1'b0;
    tick(40);
    checks++;
    if (rise_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_count got %0d strobes want 2", rise_q.size());
    end else begin
      checks++;
      if (rise_q[1] - rise_q[0] != 1 + SC + GC + 1) begin
        errors++;
        $display("FAIL b2b_spacing got %0d want %0d", rise_q[1] - rise_q[0], 1 + SC + GC + 1);
      end
    end
    checks++;
    if (exp_q.size() != 0 || cmd_count !== exp_count) begin
      errors++;
      $display("FAIL b2b_done got pending=%0d count=%0d want 0/%0d", exp_q.size(), cmd_count, exp_count);
      exp_q.delete();
    end
  endtask

  task automatic test_wrap;
    reset = 1'b1;
    exp_count = 8'd0;
    tick(3);
    reset = 1'b0;
    tick(2);
    for (int n = 0; n < 300; n++) begin
      btn_rotate = 1'b1;
      expect_cmd(CMD_ROTATE);
      tick(8);
      btn_rotate = 1'b0;
      tick(8);
    end
    tick(40);
    checks++;
    if (exp_q.size() != 0 || cmd_count !== exp_count) begin
      errors++;
      $display("FAIL wrap_count got pending=%0d count=%0d want 0/%0d", exp_q.size(), cmd_count, exp_count);
      exp_q.delete();
    end
  endtask

  task automatic test_reset_in_strobe;
    bit seen = 0;
    btn_left = 1'b1;
    expect_cmd(CMD_LEFT);
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk); #2;
      if (move_clk === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_strobe_timeout got no move_clk within 30 cycles want a strobe");
    end
    @(negedge clk);
    reset = 1'b1;
    btn_left = 1'b0;
    exp_count = 8'd0;
    exp_q.delete();
    @(posedge clk); #2;
    checks++;
    if (move_clk !== 1'b0 || move_valid !== 1'b0 || cmd_count !== 8'd0) begin
      errors++;
      $display("FAIL rst_strobe_drop got clk=%b valid=%b count=%0d want 0/0/0", move_clk, move_valid, cmd_count);
    end
    tick(2);
    reset = 1'b0;
    rise_q.delete();
    tick(40);
    checks++;
    if (rise_q.size() != 0 || cmd_count !== exp_count) begin
      errors++;
      $display("FAIL rst_strobe_extra got strobes=%0d count=%0d want 0/%0d", rise_q.size(), cmd_count, exp_count);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_glitch();
    test_single_left();
    test_repeat_right();
    test_rotate();
    test_back_to_back();
    test_wrap();
    test_reset_in_strobe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
